idu_queue_decode: RTL and testbench
===================================

Name: idu_queue_decode

Overview:
- Next-generation instruction decode stage for the NPC core.
- An inbound instruction queue of parametrised depth (inst + pc) sits between IFU and a registered decoder. The decoder drives a pipelined control bundle to EXU.
- Valid/ready on both sides, plus a flush for branch/trap redirect.
- Adds MULHSU/MULHU decode, a pc sideband and queue occupancy.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- flush  in  1  discard queue and output register.
- in_valid  in  1  IFU offers instruction.
- in_ready  out  1  queue can accept.
- in_inst  in  32  instruction word.
- in_pc  in  32  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  EXU accepts bundle.
- out_pc  out  32  pc of the decoded instruction.
- out_rd / out_rs1 / out_rs2  out  5 each  register addresses.
- out_imm  out  32  sign/zero-extended immediate (I/S/B/U/J by opcode, else 0).
- out_alu_op  out  5  ALU op code.
- out_alu_a_sel  out  2  0 = rs1, 1 = pc, 2 = zero.
- out_alu_b_sel  out  1  0 = rs2, 1 = imm.
- out_result_sel  out  2  0 = alu, 1 = csr, 2 = pc+4.
- out_flags  out  8  {inst_invalid, is_mret, is_ecall, is_jalr, is_jal, is_branch, is_store, is_load}.
- out_reg_we  out  1  register write enable.
- out_csr_op  out  2  0 = none, 1 = csrrw, 2 = csrrs.
- out_csr_addr  out  12  CSR address (0 unless SYSTEM).
- occupancy  out  CNT_W  valid queue entries.

Behaviour:
- Reset (rst_n = 0, async): queue pointers and count cleared; out_valid = 0; all out_* bundle registers = 0; occupancy = 0.
- in_ready = (count != DEPTH) && !flush. It has no combinational dependence on out_ready: a full queue does not accept even while dequeuing.
- Enqueue when in_valid && in_ready. Write pointer wraps modulo DEPTH.
- Dequeue/load: when count != 0 and (!out_valid || out_ready), the head is decoded combinationally and captured into the out register at the edge. The read pointer then advances and out_valid = 1.
- If out_valid && out_ready and the queue is empty, out_valid falls to 0 at the edge.
- While out_valid && !out_ready, the bundle holds stable.
- Latency: an instruction enqueued at edge t into an empty idle block is presented on out_* after edge t+1 (2 cycles in, first visible out). Throughput is 1 per cycle when DEPTH >= 2.
- Simultaneous enqueue and dequeue: count unchanged.
- flush has priority over all events. At the next edge: count = 0, pointers = 0, out_valid = 0. in_valid in the flush cycle is dropped.
- Decode rules:
  - Valid opcodes: LUI, AUIPC, JAL, JALR (funct3 = 0), LOAD (funct3 0, 1, 2, 4, 5), STORE (0, 1, 2), BRANCH (funct3 != 2, 3), OP-IMM (shifts require funct7 0 or 0x20 on SRAI), OP.
  - SYSTEM covers ECALL 0x000, EBREAK 0x001, MRET 0x302, CSRRW, CSRRS.
  - Anything else sets inst_invalid, with reg_we = 0 and alu_op = ADD.
- ALU codes:
  - ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
  - MUL 10, MULH 11, DIV 12, DIVU 13, REM 14, REMU 15, MULHSU 16, MULHU 17.
- Operand selects:
  - alu_a_sel: zero for LUI; pc for AUIPC/JAL/BRANCH; rs1 otherwise.
  - alu_b_sel = rs2 only for OP.
- result_sel: pc+4 for JAL/JALR, csr for CSRRW/CSRRS, alu otherwise.
- reg_we for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, CSRRW, CSRRS.
- An invalid instruction still flows through the queue. It is not dropped.

Optional Feature:
- Macro IDU_RV32M_EN.
- Defined: OP with funct7 = 0000001 decodes to MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU (funct3 0..7).
- Undefined: those encodings set inst_invalid = 1 and reg_we = 0. ALU codes 10..17 are never emitted.

Decomposition:
- Package idu_pkg holds:
  - ALU_* (5-bit) codes and ALU_A_*/ALU_B_* selects.
  - RES_* and CSR_OP_* codes.
  - OPC_* opcode constants.
  - FLAG_* bit indices.
  - A packed decode-bundle struct typedef.
- One sub-module, idu_decode_comb: purely combinational inst → bundle. It is instantiated on the queue head.
- The queue and output register live in the top.

Test Plan:
- Reset/fill:
  - After rst_n release, occupancy = 0, out_valid = 0, in_ready = 1.
  - With out_ready = 0, push 5 instrs at DEPTH = 4: the first enters the out register, 4 remain queued, in_ready = 0, occupancy = 4.
- Streaming:
  - out_ready = 1; push 0x00500093 (addi x1, x0, 5) at pc 0x80000000.
  - Two edges later: out_valid = 1, rd = 1, imm = 5, alu_op = 0, alu_b_sel = 1, reg_we = 1, out_pc = 0x80000000.
  - Back-to-back pushes yield one bundle per cycle.
- Backpressure:
  - Hold out_ready = 0 for 3 cycles with 0x40208133 (sub) on out.
  - Bundle stable, alu_op = 1, alu_b_sel = 0.
- Flush:
  - With occupancy = 3 and out_valid = 1, assert flush together with in_valid.
  - Next cycle: occupancy = 0, out_valid = 0, and the pushed instruction is absent.
- Decode corners:
  - 0x0000006F (jal): result_sel = 2, alu_a_sel = 1, imm = 0.
  - 0x30200073 (mret): is_mret = 1.
  - 0x30529073 (csrrw): csr_op = 1, csr_addr = 0x305, reg_we = 1.
  - 0xFFFFFFFF: inst_invalid = 1, reg_we = 0.
- M option:
  - 0x022081B3 (mul): with IDU_RV32M_EN, alu_op = 10.
  - 0x0220B1B3 (mulhu): alu_op = 17.
  - Without the macro, both give inst_invalid = 1.

Source files
------------

// File: rtl/idu_pkg.sv
// Shared encodings for the instruction decode stage: ALU/select/result codes, opcodes, flag bits
// and the packed decode bundle carried from the decoder to the EXU-facing output register.
package idu_pkg;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_MUL    = 5'd10;
    localparam logic [4:0] ALU_MULH   = 5'd11;
    localparam logic [4:0] ALU_DIV    = 5'd12;
    localparam logic [4:0] ALU_DIVU   = 5'd13;
    localparam logic [4:0] ALU_REM    = 5'd14;
    localparam logic [4:0] ALU_REMU   = 5'd15;
    localparam logic [4:0] ALU_MULHSU = 5'd16;
    localparam logic [4:0] ALU_MULHU  = 5'd17;

    localparam logic [1:0] ALU_A_RS1  = 2'd0;
    localparam logic [1:0] ALU_A_PC   = 2'd1;
    localparam logic [1:0] ALU_A_ZERO = 2'd2;
    localparam logic       ALU_B_RS2  = 1'b0;
    localparam logic       ALU_B_IMM  = 1'b1;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_CSR = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;

    localparam logic [1:0] CSR_OP_NONE = 2'd0;
    localparam logic [1:0] CSR_OP_RW   = 2'd1;
    localparam logic [1:0] CSR_OP_RS   = 2'd2;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int FLAG_LOAD    = 0;
    localparam int FLAG_STORE   = 1;
    localparam int FLAG_BRANCH  = 2;
    localparam int FLAG_JAL     = 3;
    localparam int FLAG_JALR    = 4;
    localparam int FLAG_ECALL   = 5;
    localparam int FLAG_MRET    = 6;
    localparam int FLAG_INVALID = 7;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [4:0]  alu_op;
        logic [1:0]  alu_a_sel;
        logic        alu_b_sel;
        logic [1:0]  result_sel;
        logic [7:0]  flags;
        logic        reg_we;
        logic [1:0]  csr_op;
        logic [11:0] csr_addr;
    } dec_bundle_t;

    // Immediate format is chosen purely by opcode; SYSTEM and unknown opcodes yield zero.
    function automatic logic [31:0] imm_gen(input logic [31:0] inst);
        logic [31:0] imm;
        imm = '0;
        case (inst[6:0])
            OPC_JALR, OPC_LOAD, OPC_OPIMM: imm = {{20{inst[31]}}, inst[31:20]};
            OPC_STORE:  imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC: imm = {inst[31:12], 12'b0};
            OPC_JAL:    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:    imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/idu_decode_comb.sv
// Purely combinational RV32I(+M) instruction -> decode bundle; zero latency, no flow control.
// Optional IDU_RV32M_EN enables the M extension; otherwise funct7=0000001 OP encodings are invalid.
module idu_decode_comb
    import idu_pkg::*;
(
    input  logic [31:0]  inst,
    output dec_bundle_t  bundle
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        invalid;
    dec_bundle_t b;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    always_comb begin
        b            = '0;
        invalid      = 1'b0;
        b.rd         = inst[11:7];
        b.rs1        = inst[19:15];
        b.rs2        = inst[24:20];
        b.imm        = imm_gen(inst);
        b.alu_op     = ALU_ADD;
        b.alu_a_sel  = ALU_A_RS1;
        b.alu_b_sel  = ALU_B_IMM;
        b.result_sel = RES_ALU;
        b.csr_op     = CSR_OP_NONE;

        case (opcode)
            OPC_LUI: begin
                b.alu_a_sel = ALU_A_ZERO;
                b.reg_we    = 1'b1;
            end
            OPC_AUIPC: begin
                b.alu_a_sel = ALU_A_PC;
                b.reg_we    = 1'b1;
            end
            OPC_JAL: begin
                b.alu_a_sel          = ALU_A_PC;
                b.result_sel         = RES_PC4;
                b.reg_we             = 1'b1;
                b.flags[FLAG_JAL]    = 1'b1;
            end
            OPC_JALR: begin
                invalid              = (funct3 != 3'd0);
                b.result_sel         = RES_PC4;
                b.reg_we             = 1'b1;
                b.flags[FLAG_JALR]   = 1'b1;
            end
            OPC_LOAD: begin
                invalid              = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
                b.reg_we             = 1'b1;
                b.flags[FLAG_LOAD]   = 1'b1;
            end
            OPC_STORE: begin
                invalid              = (funct3 > 3'd2);
                b.flags[FLAG_STORE]  = 1'b1;
            end
            OPC_BRANCH: begin
                invalid              = (funct3 == 3'd2) || (funct3 == 3'd3);
                b.alu_a_sel          = ALU_A_PC;
                b.flags[FLAG_BRANCH] = 1'b1;
            end
            OPC_OPIMM: begin
                b.reg_we = 1'b1;
                case (funct3)
                    3'd0: b.alu_op = ALU_ADD;
                    3'd1: begin
                        b.alu_op = ALU_SLL;
                        invalid  = (funct7 != 7'h00);
                    end
                    3'd2: b.alu_op = ALU_SLT;
                    3'd3: b.alu_op = ALU_SLTU;
                    3'd4: b.alu_op = ALU_XOR;
                    3'd5: begin
                        b.alu_op = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
                        invalid  = (funct7 != 7'h00) && (funct7 != 7'h20);
                    end
                    3'd6: b.alu_op = ALU_OR;
                    default: b.alu_op = ALU_AND;
                endcase
            end
            OPC_OP: begin
                b.reg_we    = 1'b1;
                b.alu_b_sel = ALU_B_RS2;
                case (funct7)
                    7'h00: begin
                        case (funct3)
                            3'd0: b.alu_op = ALU_ADD;
                            3'd1: b.alu_op = ALU_SLL;
                            3'd2: b.alu_op = ALU_SLT;
                            3'd3: b.alu_op = ALU_SLTU;
                            3'd4: b.alu_op = ALU_XOR;
                            3'd5: b.alu_op = ALU_SRL;
                            3'd6: b.alu_op = ALU_OR;
                            default: b.alu_op = ALU_AND;
                        endcase
                    end
                    7'h20: begin
                        if (funct3 == 3'd0)      b.alu_op = ALU_SUB;
                        else if (funct3 == 3'd5) b.alu_op = ALU_SRA;
                        else                     invalid  = 1'b1;
                    end
`ifdef IDU_RV32M_EN
                    7'h01: begin
                        case (funct3)
                            3'd0: b.alu_op = ALU_MUL;
                            3'd1: b.alu_op = ALU_MULH;
                            3'd2: b.alu_op = ALU_MULHSU;
                            3'd3: b.alu_op = ALU_MULHU;
                            3'd4: b.alu_op = ALU_DIV;
                            3'd5: b.alu_op = ALU_DIVU;
                            3'd6: b.alu_op = ALU_REM;
                            default: b.alu_op = ALU_REMU;
                        endcase
                    end
`else
                    7'h01: invalid = 1'b1;
`endif
                    default: invalid = 1'b1;
                endcase
            end
            OPC_SYSTEM: begin
                b.csr_addr = inst[31:20];
                case (funct3)
                    3'd0: begin
                        // Privileged forms carry no register operands.
                        if (inst[19:7] != 13'd0)          invalid = 1'b1;
                        else if (inst[31:20] == 12'h000)  b.flags[FLAG_ECALL] = 1'b1;
                        else if (inst[31:20] == 12'h302)  b.flags[FLAG_MRET]  = 1'b1;
                        else if (inst[31:20] != 12'h001)  invalid = 1'b1;
                    end
                    3'd1: begin
                        b.csr_op     = CSR_OP_RW;
                        b.result_sel = RES_CSR;
                        b.reg_we     = 1'b1;
                    end
                    3'd2: begin
                        b.csr_op     = CSR_OP_RS;
                        b.result_sel = RES_CSR;
                        b.reg_we     = 1'b1;
                    end
                    default: invalid = 1'b1;
                endcase
            end
            default: invalid = 1'b1;
        endcase

        // Invalid instructions travel on as inert bundles: no side effects, only the flag.
        if (invalid) begin
            b.reg_we              = 1'b0;
            b.alu_op              = ALU_ADD;
            b.alu_a_sel           = ALU_A_RS1;
            b.alu_b_sel           = ALU_B_IMM;
            b.result_sel          = RES_ALU;
            b.csr_op              = CSR_OP_NONE;
            b.flags               = '0;
            b.flags[FLAG_INVALID] = 1'b1;
        end
    end

    assign bundle = b;

endmodule

// File: rtl/idu_queue_decode.sv
// Decode stage: DEPTH-entry inst/pc queue feeding a registered decoder; first bundle visible one edge after enqueue.
// in_ready depends only on occupancy and flush; output register holds while out_valid && !out_ready. Optional: IDU_RV32M_EN.
module idu_queue_decode
    import idu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [31:0]      out_imm,
    output logic [4:0]       out_alu_op,
    output logic [1:0]       out_alu_a_sel,
    output logic             out_alu_b_sel,
    output logic [1:0]       out_result_sel,
    output logic [7:0]       out_flags,
    output logic             out_reg_we,
    output logic [1:0]       out_csr_op,
    output logic [11:0]      out_csr_addr,
    output logic [CNT_W-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             load;
    dec_bundle_t      head_bundle;
    dec_bundle_t      out_q;
    logic [31:0]      out_pc_q;
    logic             out_valid_q;

    assign in_ready = (count != CNT_W'(DEPTH)) && !flush;
    assign push     = in_valid && in_ready;
    assign load     = (count != '0) && (!out_valid_q || out_ready);

    idu_decode_comb u_dec (
        .inst   (inst_mem[rd_ptr]),
        .bundle (head_bundle)
    );

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= in_inst;
            pc_mem[wr_ptr]   <= in_pc;
        end
    end

    // Power-of-two DEPTH lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (load) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, load})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_pc_q    <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_q       <= head_bundle;
            out_pc_q    <= pc_mem[rd_ptr];
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_pc         = out_pc_q;
    assign out_rd         = out_q.rd;
    assign out_rs1        = out_q.rs1;
    assign out_rs2        = out_q.rs2;
    assign out_imm        = out_q.imm;
    assign out_alu_op     = out_q.alu_op;
    assign out_alu_a_sel  = out_q.alu_a_sel;
    assign out_alu_b_sel  = out_q.alu_b_sel;
    assign out_result_sel = out_q.result_sel;
    assign out_flags      = out_q.flags;
    assign out_reg_we     = out_q.reg_we;
    assign out_csr_op     = out_q.csr_op;
    assign out_csr_addr   = out_q.csr_addr;
    assign occupancy      = count;

endmodule

// File: tb/tb_idu_queue_decode.sv
// Directed bench for idu_queue_decode: inputs driven and outputs sampled on the falling clock edge.
module tb_idu_queue_decode;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [31:0]      in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [31:0]      out_imm;
    logic [4:0]       out_alu_op;
    logic [1:0]       out_alu_a_sel;
    logic             out_alu_b_sel;
    logic [1:0]       out_result_sel;
    logic [7:0]       out_flags;
    logic             out_reg_we;
    logic [1:0]       out_csr_op;
    logic [11:0]      out_csr_addr;
    logic [CNT_W-1:0] occupancy;

    int checks = 0;
    int errors = 0;

    idu_queue_decode #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_inst        (in_inst),
        .in_pc          (in_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_rd         (out_rd),
        .out_rs1        (out_rs1),
        .out_rs2        (out_rs2),
        .out_imm        (out_imm),
        .out_alu_op     (out_alu_op),
        .out_alu_a_sel  (out_alu_a_sel),
        .out_alu_b_sel  (out_alu_b_sel),
        .out_result_sel (out_result_sel),
        .out_flags      (out_flags),
        .out_reg_we     (out_reg_we),
        .out_csr_op     (out_csr_op),
        .out_csr_addr   (out_csr_addr),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Push one instruction into an idle block with out_ready high; returns when it sits in the out register.
    task automatic run_one(input logic [31:0] inst, input logic [31:0] pc);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("one_valid", 32'(out_valid), 32'd1);
        chk("one_pc", out_pc, pc);
    endtask

    logic [31:0] pcs [3];

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_flags", 32'(out_flags), 32'd0);

        // addi x1, x0, 5
        run_one(32'h00500093, 32'h80000000);
        chk("addi_rd", 32'(out_rd), 32'd1);
        chk("addi_imm", out_imm, 32'd5);
        chk("addi_alu", 32'(out_alu_op), 32'd0);
        chk("addi_bsel", 32'(out_alu_b_sel), 32'd1);
        chk("addi_we", 32'(out_reg_we), 32'd1);
        @(negedge clk);
        chk("addi_drained", 32'(out_valid), 32'd0);

        // Back-to-back stream: one bundle per cycle.
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) begin
                chk("stream_valid", 32'(out_valid), 32'd1);
                chk("stream_pc", out_pc, pcs[i-2]);
                chk("stream_imm", out_imm, 32'(i - 1));
            end
            if (i < 3) begin
                in_valid = 1'b1;
                in_inst  = {12'(i + 1), 20'h00093};
                in_pc    = pcs[i];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("stream_drained", 32'(out_valid), 32'd0);

        // Backpressure with sub x2, x1, x2 held on the output.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h40208133;
        in_pc     = 32'h500;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_pc", out_pc, 32'h500);
            chk("bp_alu", 32'(out_alu_op), 32'd1);
            chk("bp_bsel", 32'(out_alu_b_sel), 32'd0);
            chk("bp_rd", 32'(out_rd), 32'd2);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Fill: five pushes with out_ready low -> one in the out register, DEPTH queued.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_inst  = 32'h00000013;
            in_pc    = 32'h200 + 32'(4 * k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("fill_occ", 32'(occupancy), 32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_out_pc", out_pc, 32'h200);

        // A full queue refuses a push even while it dequeues.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h300;
        #1;
        chk("full_deq_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("deq_occ", 32'(occupancy), 32'd3);
        chk("deq_out_pc", out_pc, 32'h204);
        chk("deq_out_valid", 32'(out_valid), 32'd1);

        // Flush with a simultaneous push.
        flush    = 1'b1;
        in_valid = 1'b1;
        in_inst  = 32'h00700093;
        in_pc    = 32'h400;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("flush_no_push_valid", 32'(out_valid), 32'd0);
        chk("flush_no_push_occ", 32'(occupancy), 32'd0);

        // Pointers restart at zero after flush.
        run_one(32'h123450B7, 32'h600);
        chk("lui_imm", out_imm, 32'h12345000);
        chk("lui_asel", 32'(out_alu_a_sel), 32'd2);
        chk("lui_we", 32'(out_reg_we), 32'd1);
        @(negedge clk);

        run_one(32'h0000006F, 32'h604);
        chk("jal_res", 32'(out_result_sel), 32'd2);
        chk("jal_asel", 32'(out_alu_a_sel), 32'd1);
        chk("jal_imm", out_imm, 32'd0);
        chk("jal_flags", 32'(out_flags), 32'h08);
        @(negedge clk);

        run_one(32'h30200073, 32'h608);
        chk("mret_flags", 32'(out_flags), 32'h40);
        chk("mret_we", 32'(out_reg_we), 32'd0);
        @(negedge clk);

        run_one(32'h30529073, 32'h60C);
        chk("csrrw_op", 32'(out_csr_op), 32'd1);
        chk("csrrw_addr", 32'(out_csr_addr), 32'h305);
        chk("csrrw_we", 32'(out_reg_we), 32'd1);
        chk("csrrw_res", 32'(out_result_sel), 32'd1);
        @(negedge clk);

        // sw x1, 4(x2)
        run_one(32'h00112223, 32'h610);
        chk("sw_imm", out_imm, 32'd4);
        chk("sw_flags", 32'(out_flags), 32'h02);
        chk("sw_we", 32'(out_reg_we), 32'd0);
        @(negedge clk);

        run_one(32'hFFFFFFFF, 32'h614);
        chk("inv_flags", 32'(out_flags), 32'h80);
        chk("inv_we", 32'(out_reg_we), 32'd0);
        chk("inv_alu", 32'(out_alu_op), 32'd0);
        @(negedge clk);

        run_one(32'h022081B3, 32'h618);
`ifdef IDU_RV32M_EN
        chk("mul_alu", 32'(out_alu_op), 32'd10);
        chk("mul_we", 32'(out_reg_we), 32'd1);
`else
        chk("mul_flags", 32'(out_flags), 32'h80);
        chk("mul_we", 32'(out_reg_we), 32'd0);
`endif
        @(negedge clk);

        run_one(32'h0220B1B3, 32'h61C);
`ifdef IDU_RV32M_EN
        chk("mulhu_alu", 32'(out_alu_op), 32'd17);
        chk("mulhu_flags", 32'(out_flags), 32'h00);
`else
        chk("mulhu_flags", 32'(out_flags), 32'h80);
        chk("mulhu_alu", 32'(out_alu_op), 32'd0);
`endif
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
